// File: rtl/dds_sweep_ctrl.sv
// dds_sweep_ctrl: steps a DDS frequency tuning word from start to stop in fixed
// increments, holding each value for a programmable dwell. Each new word goes to the
// phase accumulator through a valid/ack handshake. odone marks each pass end.
// Optional feature macro: DDS_SWEEP_WAVE_CYCLE_EN
//   defined   - owave_sel is an internal counter that advances on every odone
//   undefined - owave_sel is iwave_sel delayed by one register
module dds_sweep_ctrl #(
   parameter int FTW_W    = 11,
   parameter int DWELL_W  = 16,
   parameter int WAVE_NUM = 4
) (
   input  logic               iclk,
   input  logic               irst,
   input  logic               istart,
   input  logic               istop,
   input  logic               imode,
   input  logic [FTW_W-1:0]   ifreq_start,
   input  logic [FTW_W-1:0]   ifreq_stop,
   input  logic [FTW_W-1:0]   ifreq_step,
   input  logic [DWELL_W-1:0] idwell,
   input  logic [1:0]         iwave_sel,
   input  logic               iftw_ack,
   output logic [FTW_W-1:0]   oftw,
   output logic               oftw_valid,
   output logic [1:0]         owave_sel,
   output logic               obusy,
   output logic               odone
);

   typedef enum logic [1:0] {IDLE, WAIT_ACK, DWELL, STEP} state_t;

   state_t             state_q, state_d;
   logic [FTW_W-1:0]   ftw_q, ftw_d;
   logic [FTW_W-1:0]   start_q, start_d;
   logic [FTW_W-1:0]   stop_q, stop_d;
   logic [FTW_W-1:0]   step_q, step_d;
   logic [DWELL_W-1:0] dwell_q, dwell_d;
   logic [DWELL_W-1:0] cnt_q, cnt_d;
   logic               mode_q, mode_d;
   logic               down_q, down_d;
   logic               done_q, done_d;
   logic [1:0]         wave_q, wave_d;

   logic [FTW_W:0]     sum_up;
   logic [FTW_W:0]     start_plus_step;
   logic               up_ok;
   logic               down_ok;
   logic               degenerate;
   logic [FTW_W-1:0]   next_ftw;
   logic               next_down;
   logic               pass_end;

   // Next tuning word, direction and pass-end flag; one extra bit catches overflow
   always_comb begin
      sum_up          = {1'b0, ftw_q} + {1'b0, step_q};
      start_plus_step = {1'b0, start_q} + {1'b0, step_q};
      up_ok           = (sum_up <= {1'b0, stop_q});
      down_ok         = ({1'b0, ftw_q} >= start_plus_step);
      degenerate      = (start_q > stop_q) || (step_q == '0);
      next_ftw        = ftw_q;
      next_down       = down_q;
      pass_end        = 1'b0;
      if (degenerate) begin
         next_ftw = start_q;
         pass_end = 1'b1;
      end else if (!down_q) begin
         if (up_ok) begin
            next_ftw = sum_up[FTW_W-1:0];
         end else begin
            pass_end = 1'b1;
            if (!mode_q) begin
               next_ftw = start_q;
            end else begin
               next_down = 1'b1;
               if (down_ok) begin
                  next_ftw = ftw_q - step_q;
               end
            end
         end
      end else begin
         if (down_ok) begin
            next_ftw = ftw_q - step_q;
         end else begin
            pass_end  = 1'b1;
            next_down = 1'b0;
            if (up_ok) begin
               next_ftw = sum_up[FTW_W-1:0];
            end
         end
      end
   end

   // Sweep FSM: stop wins over everything, start only accepted from IDLE
   always_comb begin
      state_d = state_q;
      ftw_d   = ftw_q;
      start_d = start_q;
      stop_d  = stop_q;
      step_d  = step_q;
      dwell_d = dwell_q;
      cnt_d   = cnt_q;
      mode_d  = mode_q;
      down_d  = down_q;
      done_d  = 1'b0;
      if (istop) begin
         state_d = IDLE;
      end else begin
         case (state_q)
            IDLE: begin
               if (istart) begin
                  state_d = WAIT_ACK;
                  start_d = ifreq_start;
                  stop_d  = ifreq_stop;
                  step_d  = ifreq_step;
                  dwell_d = (idwell == '0) ? DWELL_W'(1) : idwell;
                  mode_d  = imode;
                  ftw_d   = ifreq_start;
                  down_d  = 1'b0;
               end
            end
            WAIT_ACK: begin
               if (iftw_ack) begin
                  state_d = DWELL;
                  cnt_d   = dwell_q;
               end
            end
            DWELL: begin
               if (cnt_q <= DWELL_W'(1)) begin
                  state_d = STEP;
                  cnt_d   = '0;
               end else begin
                  cnt_d = cnt_q - DWELL_W'(1);
               end
            end
            STEP: begin
               state_d = WAIT_ACK;
               ftw_d   = next_ftw;
               down_d  = next_down;
               done_d  = pass_end;
            end
            default: state_d = IDLE;
         endcase
      end
   end

`ifdef DDS_SWEEP_WAVE_CYCLE_EN
   logic unused_wave_sel;
   assign unused_wave_sel = ^iwave_sel;

   // Waveform index advances once per pass end and survives stop/restart
   always_comb begin
      wave_d = wave_q;
      if (done_d) begin
         wave_d = (wave_q == 2'(WAVE_NUM - 1)) ? 2'd0 : wave_q + 2'd1;
      end
   end
`else
   // Waveform index simply follows the external select one cycle late
   always_comb begin
      wave_d = iwave_sel;
   end
`endif

   // State and datapath registers
   always_ff @(posedge iclk or posedge irst) begin
      if (irst) begin
         state_q <= IDLE;
         ftw_q   <= '0;
         start_q <= '0;
         stop_q  <= '0;
         step_q  <= '0;
         dwell_q <= '0;
         cnt_q   <= '0;
         mode_q  <= 1'b0;
         down_q  <= 1'b0;
         done_q  <= 1'b0;
         wave_q  <= '0;
      end else begin
         state_q <= state_d;
         ftw_q   <= ftw_d;
         start_q <= start_d;
         stop_q  <= stop_d;
         step_q  <= step_d;
         dwell_q <= dwell_d;
         cnt_q   <= cnt_d;
         mode_q  <= mode_d;
         down_q  <= down_d;
         done_q  <= done_d;
         wave_q  <= wave_d;
      end
   end

   assign oftw       = ftw_q;
   assign oftw_valid = (state_q == WAIT_ACK);
   assign obusy      = (state_q != IDLE);
   assign odone      = done_q;
   assign owave_sel  = wave_q;

endmodule
